stim_serial_rx: RTL and testbench

- Receive-side monitor/deserializer for the stimulator serial interface: the receiving end of the chip-drive link (serial clock, serial data, resn, enable, 4-bit address select).
- Oversamples the link on a faster local clock, rebuilds 8-bit channel words, tags each word with channel index and address, and decodes the two-word reset command.
- Serves as the loopback checker on the FPGA and as the chip-side model in benches.

---
 rtl/stim_rx_pkg.sv | 8 +
 rtl/stim_rx_sync_edge.sv | 36 +++
 rtl/stim_serial_rx.sv | 179 +++++++++++++++++
 tb/tb_stim_serial_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_rx_pkg.sv
// Shared types and constants for the stimulator serial link receiver.
package stim_rx_pkg;
  typedef enum logic [1:0] {IDLE, RESET_SEQ, RUN} state_t;

  localparam int         DEF_WORD_W  = 8;
  localparam logic [7:0] RESET_WORD  = 8'hFF;
  localparam int         RESET_WORDS = 2;
endpackage

// File: rtl/stim_rx_sync_edge.sv
// Multi-flop synchronizer with registered level and edge outputs; optional
// side data travels through the same stages so it stays aligned with the edge.
module stim_rx_sync_edge #(
  parameter int STAGES = 2,
  parameter int DATA_W = 1
) (
  input  logic              clk_in,
  input  logic              bt_res,
  input  logic              sig,
  input  logic [DATA_W-1:0] data,
  output logic              lvl,
  output logic              rise,
  output logic              fall,
  output logic [DATA_W-1:0] data_out
);
  logic [STAGES-1:0]             sig_q;
  logic [STAGES-1:0][DATA_W-1:0] dat_q;

  always_ff @(posedge clk_in) begin
    if (bt_res) begin
      sig_q    <= '0;
      dat_q    <= '0;
      lvl      <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      data_out <= '0;
    end else begin
      sig_q    <= {sig_q[STAGES-2:0], sig};
      dat_q    <= {dat_q[STAGES-2:0], data};
      lvl      <= sig_q[STAGES-1];
      rise     <= sig_q[STAGES-1] & ~lvl;
      fall     <= ~sig_q[STAGES-1] & lvl;
      data_out <= dat_q[STAGES-1];
    end
  end
endmodule

// File: rtl/stim_serial_rx.sv
// Oversampling receiver for the stimulator serial link: rebuilds channel words,
// counts frames and decodes the two-word reset command.
module stim_serial_rx
  import stim_rx_pkg::*;
#(
  parameter int WORD_W      = DEF_WORD_W,
  parameter int NUM_CHA     = 2,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_in,
  input  logic              bt_res,
  input  logic              rx_sclk,
  input  logic              rx_din,
  input  logic              rx_resn,
  input  logic              rx_enable,
  input  logic [3:0]        rx_sel,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data,
  output logic [3:0]        word_cha,
  output logic [3:0]        word_addr,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              reset_active,
  output logic              reset_cmd,
  output logic              err_abort
);
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic       bit_ev, sclk_lvl, sclk_fall;
  logic [4:0] sd;
  logic       resn_lvl, resn_rise, resn_fall, resn_dat;
  logic       en_lvl, en_rise, en_fall, en_dat;
  logic       din;
  logic [3:0] sel;
  logic       unused_sink;

  stim_rx_sync_edge #(.STAGES(SYNC_STAGES), .DATA_W(5)) u_sclk (
    .clk_in, .bt_res, .sig(rx_sclk), .data({rx_sel, rx_din}),
    .lvl(sclk_lvl), .rise(bit_ev), .fall(sclk_fall), .data_out(sd));
  stim_rx_sync_edge #(.STAGES(SYNC_STAGES), .DATA_W(1)) u_resn (
    .clk_in, .bt_res, .sig(rx_resn), .data(1'b0),
    .lvl(resn_lvl), .rise(resn_rise), .fall(resn_fall), .data_out(resn_dat));
  stim_rx_sync_edge #(.STAGES(SYNC_STAGES), .DATA_W(1)) u_en (
    .clk_in, .bt_res, .sig(rx_enable), .data(1'b0),
    .lvl(en_lvl), .rise(en_rise), .fall(en_fall), .data_out(en_dat));

  assign din         = sd[0];
  assign sel         = sd[4:1];
  assign unused_sink = ^{sclk_lvl, sclk_fall, resn_lvl, resn_rise, resn_dat, en_rise, en_fall, en_dat};

  state_t             state, state_n;
  logic [BIT_W-1:0]   bit_cnt, bit_n;
  logic [3:0]         word_cnt, wcnt_n, addr_cap, addr_n, addr_w, cha_v;
  logic [WORD_W-1:0]  sh, sh_n, shifted;
  logic               rst_ok, ok_n, wv, fd, rc, ea, last;

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    wcnt_n  = word_cnt;
    sh_n    = sh;
    addr_n  = addr_cap;
    ok_n    = rst_ok;
    wv      = 1'b0;
    fd      = 1'b0;
    rc      = 1'b0;
    ea      = 1'b0;
    cha_v   = 4'd0;
    shifted = (MSB_FIRST != 0) ? {sh[WORD_W-2:0], din} : {din, sh[WORD_W-1:1]};
    last    = (bit_cnt == BIT_W'(WORD_W-1));
    addr_w  = (bit_cnt == '0) ? sel : addr_cap;
    case (state)
      IDLE: begin
        // Falling edge (not level) so a resn still low after a sequence cannot re-trigger it.
        if (resn_fall) begin
          state_n = RESET_SEQ;
          bit_n   = '0;
          wcnt_n  = '0;
          ok_n    = 1'b1;
        end else if (en_lvl) begin
          state_n = RUN;
          bit_n   = '0;
          wcnt_n  = '0;
        end
      end
      RESET_SEQ: begin
        if (bit_ev) begin
          sh_n   = shifted;
          addr_n = addr_w;
          if (last) begin
            bit_n = '0;
            wv    = 1'b1;
            ok_n  = rst_ok & (shifted == WORD_W'(RESET_WORD));
            if (word_cnt == 4'(RESET_WORDS-1)) begin
              state_n = IDLE;
              wcnt_n  = '0;
              rc      = ok_n;
              ea      = ~ok_n;
            end else begin
              wcnt_n = word_cnt + 4'd1;
            end
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      RUN: begin
        if (resn_fall) begin
          state_n = RESET_SEQ;
          bit_n   = '0;
          wcnt_n  = '0;
          ok_n    = 1'b1;
          ea      = (bit_cnt != '0);
        end else if (!en_lvl) begin
          state_n = IDLE;
          bit_n   = '0;
          wcnt_n  = '0;
          ea      = (bit_cnt != '0);
        end else if (bit_ev) begin
          sh_n   = shifted;
          addr_n = addr_w;
          if (last) begin
            bit_n = '0;
            wv    = 1'b1;
            cha_v = word_cnt;
            if (word_cnt == 4'(NUM_CHA-1)) begin
              wcnt_n = '0;
              fd     = 1'b1;
            end else begin
              wcnt_n = word_cnt + 4'd1;
            end
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (bt_res) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      sh          <= '0;
      addr_cap    <= '0;
      rst_ok      <= 1'b0;
      word_valid  <= 1'b0;
      word_data   <= '0;
      word_cha    <= '0;
      word_addr   <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      reset_cmd   <= 1'b0;
      err_abort   <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_n;
      word_cnt   <= wcnt_n;
      sh         <= sh_n;
      addr_cap   <= addr_n;
      rst_ok     <= ok_n;
      word_valid <= wv;
      frame_done <= fd;
      reset_cmd  <= rc;
      err_abort  <= ea;
      if (wv) begin
        word_data <= sh_n;
        word_cha  <= cha_v;
        word_addr <= addr_w;
      end
      if (fd) frame_count <= frame_count + 16'd1;
    end
  end

  assign reset_active = (state == RESET_SEQ);
endmodule

// File: tb/tb_stim_serial_rx.sv
// Directed bench for stim_serial_rx: reset command, frames, long stream, aborts.
module tb_stim_serial_rx;
  localparam int HP = 2;

  logic       clk_in = 1'b0;
  logic       bt_res = 1'b1;
  logic       rx_sclk = 1'b0, rx_din = 1'b0, rx_resn = 1'b1, rx_enable = 1'b0;
  logic [3:0] rx_sel = 4'd0;
  logic       word_valid, frame_done, reset_active, reset_cmd, err_abort;
  logic [7:0] word_data;
  logic [3:0] word_cha, word_addr;
  logic [15:0] frame_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] d;
    logic [3:0] c;
    logic [3:0] a;
    logic       f;
  } wrec_t;
  wrec_t wq[$];
  int n_err = 0, n_rc = 0, n_fd = 0, n_ra = 0;

  stim_serial_rx dut (
    .clk_in(clk_in), .bt_res(bt_res), .rx_sclk(rx_sclk), .rx_din(rx_din),
    .rx_resn(rx_resn), .rx_enable(rx_enable), .rx_sel(rx_sel),
    .word_valid(word_valid), .word_data(word_data), .word_cha(word_cha),
    .word_addr(word_addr), .frame_done(frame_done), .frame_count(frame_count),
    .reset_active(reset_active), .reset_cmd(reset_cmd), .err_abort(err_abort));

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (word_valid) wq.push_back('{d: word_data, c: word_cha, a: word_addr, f: frame_done});
    if (err_abort)    n_err++;
    if (reset_cmd)    n_rc++;
    if (frame_done)   n_fd++;
    if (reset_active) n_ra++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic clr_mon();
    wq.delete();
    n_err = 0; n_rc = 0; n_fd = 0; n_ra = 0;
  endtask

  task automatic send_bit(input logic d, input logic [3:0] s);
    rx_din = d; rx_sel = s; rx_sclk = 1'b0;
    idle(HP);
    rx_sclk = 1'b1;
    idle(HP);
    rx_sclk = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic [3:0] s);
    for (int i = 7; i >= 0; i--) send_bit(w[i], s);
  endtask

  task automatic test_reset();
    bt_res = 1'b1;
    idle(3);
    total++;
    if ({word_valid, word_data, word_cha, word_addr, frame_done, frame_count,
         reset_active, reset_cmd, err_abort} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%0b data=%h cha=%0d addr=%0d fd=%0b fc=%0d ra=%0b rc=%0b ea=%0b, need all 0",
               word_valid, word_data, word_cha, word_addr, frame_done, frame_count, reset_active, reset_cmd, err_abort);
    end
    bt_res = 1'b0;
    idle(8);
  endtask

  task automatic test_reset_cmd();
    clr_mon();
    rx_resn = 1'b0;
    idle(2 * HP);
    idle(2);
    total++;
    if (reset_active !== 1'b1) begin bad++; $display("FAIL reset_active_high: got %b need 1", reset_active); end
    rx_resn = 1'b1;
    send_word(8'hFF, 4'd0);
    send_word(8'hFF, 4'd0);
    idle(10);
    total++;
    if (wq.size() != 2) begin bad++; $display("FAIL rcmd_words: got %0d need 2", wq.size()); end
    for (int k = 0; k < 2 && k < wq.size(); k++) begin
      total++;
      if (wq[k].d !== 8'hFF || wq[k].c !== 4'd0 || wq[k].a !== 4'd0) begin
        bad++; $display("FAIL rcmd_word%0d: got d=%h c=%0d a=%0d need FF/0/0", k, wq[k].d, wq[k].c, wq[k].a);
      end
    end
    total++;
    if (n_rc != 1 || n_err != 0) begin bad++; $display("FAIL rcmd_pulses: got rc=%0d err=%0d need 1/0", n_rc, n_err); end
    total++;
    if (reset_active !== 1'b0) begin bad++; $display("FAIL reset_active_low: got %b need 0", reset_active); end
    // Bits in IDLE must be ignored.
    clr_mon();
    send_word(8'h5A, 4'd0);
    idle(10);
    total++;
    if (wq.size() != 0) begin bad++; $display("FAIL idle_ignores_bits: got %0d words need 0", wq.size()); end
  endtask

  task automatic test_frame();
    int lat;
    bit found;
    clr_mon();
    rx_enable = 1'b1;
    idle(8);
    for (int i = 7; i >= 1; i--) send_bit(1'b1, 4'd0);
    rx_din = 1'b1; rx_sel = 4'd0; rx_sclk = 1'b0;
    idle(HP);
    rx_sclk = 1'b1;
    lat = 0; found = 0;
    for (int k = 1; k <= 10 && !found; k++) begin
      @(negedge clk_in);
      if (word_valid) begin found = 1; lat = k; end
    end
    rx_sclk = 1'b0;
    total++;
    if (!found || lat != 4) begin bad++; $display("FAIL word_latency: got %0d (found=%0b) need 4", lat, found); end
    send_word(8'hFE, 4'd1);
    idle(10);
    total++;
    if (wq.size() != 2) begin bad++; $display("FAIL frame_words: got %0d need 2", wq.size()); end
    else begin
      total++;
      if (wq[0].d !== 8'hFF || wq[0].c !== 4'd0 || wq[0].a !== 4'd0 || wq[0].f !== 1'b0) begin
        bad++; $display("FAIL frame_w0: got d=%h c=%0d a=%0d f=%b need FF/0/0/0", wq[0].d, wq[0].c, wq[0].a, wq[0].f);
      end
      total++;
      if (wq[1].d !== 8'hFE || wq[1].c !== 4'd1 || wq[1].a !== 4'd1 || wq[1].f !== 1'b1) begin
        bad++; $display("FAIL frame_w1: got d=%h c=%0d a=%0d f=%b need FE/1/1/1", wq[1].d, wq[1].c, wq[1].a, wq[1].f);
      end
    end
    total++;
    if (frame_count !== 16'd1 || n_fd != 1) begin bad++; $display("FAIL frame_count1: got fc=%0d fd=%0d need 1/1", frame_count, n_fd); end
  endtask

  task automatic test_stream();
    logic [7:0] e0, e1;
    clr_mon();
    for (int f = 0; f < 500; f++) begin
      e0 = (f < 250) ? 8'hFF : 8'hFE;
      e1 = (f < 250) ? 8'hFE : 8'hFF;
      send_word(e0, 4'(f));
      send_word(e1, 4'(f + 1));
    end
    idle(10);
    total++;
    if (wq.size() != 1000) begin bad++; $display("FAIL stream_words: got %0d need 1000", wq.size()); end
    for (int k = 0; k < 1000 && k < wq.size(); k++) begin
      e0 = ((k / 2) < 250) ? ((k % 2 == 0) ? 8'hFF : 8'hFE) : ((k % 2 == 0) ? 8'hFE : 8'hFF);
      total++;
      if (wq[k].d !== e0 || wq[k].c !== 4'(k % 2) || wq[k].a !== 4'((k / 2) + (k % 2)) || wq[k].f !== (k % 2 == 1)) begin
        bad++; $display("FAIL stream_w%0d: got d=%h c=%0d a=%0d f=%b need %h/%0d/%0d/%0d",
                        k, wq[k].d, wq[k].c, wq[k].a, wq[k].f, e0, k % 2, 4'((k / 2) + (k % 2)), k % 2);
      end
    end
    total++;
    if (frame_count !== 16'd501 || n_err != 0) begin bad++; $display("FAIL stream_count: got fc=%0d err=%0d need 501/0", frame_count, n_err); end
  endtask

  task automatic test_abort();
    clr_mon();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 4'd3);
    rx_enable = 1'b0;
    idle(10);
    total++;
    if (n_err != 1 || wq.size() != 0) begin bad++; $display("FAIL abort_pulse: got err=%0d words=%0d need 1/0", n_err, wq.size()); end
    clr_mon();
    rx_enable = 1'b1;
    idle(8);
    send_word(8'h3C, 4'd4);
    send_word(8'hC3, 4'd5);
    idle(10);
    total++;
    if (wq.size() != 2) begin bad++; $display("FAIL abort_recover_words: got %0d need 2", wq.size()); end
    else begin
      total++;
      if (wq[0].d !== 8'h3C || wq[0].c !== 4'd0 || wq[1].d !== 8'hC3 || wq[1].c !== 4'd1 || wq[1].a !== 4'd5) begin
        bad++; $display("FAIL abort_recover: got %h/%0d %h/%0d a=%0d need 3C/0 C3/1 a=5", wq[0].d, wq[0].c, wq[1].d, wq[1].c, wq[1].a);
      end
    end
    total++;
    if (frame_count !== 16'd502 || n_err != 0) begin bad++; $display("FAIL abort_count: got fc=%0d err=%0d need 502/0", frame_count, n_err); end
    rx_enable = 1'b0;
    idle(8);
  endtask

  task automatic test_bad_reset();
    clr_mon();
    rx_resn = 1'b0;
    idle(2 * HP + 2);
    rx_resn = 1'b1;
    send_word(8'hFF, 4'd0);
    send_word(8'h7F, 4'd0);
    idle(10);
    total++;
    if (wq.size() != 2) begin bad++; $display("FAIL badrst_words: got %0d need 2", wq.size()); end
    else begin
      total++;
      if (wq[1].d !== 8'h7F || wq[1].c !== 4'd0) begin bad++; $display("FAIL badrst_w1: got %h/%0d need 7F/0", wq[1].d, wq[1].c); end
    end
    total++;
    if (n_err != 1 || n_rc != 0 || n_ra == 0 || reset_active !== 1'b0) begin
      bad++; $display("FAIL badrst_pulses: got err=%0d rc=%0d ra_cycles=%0d ra=%b need 1/0/>0/0", n_err, n_rc, n_ra, reset_active);
    end
  endtask

  task automatic test_midword_reset();
    rx_enable = 1'b1;
    idle(8);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 4'd1);
    bt_res = 1'b1;
    idle(1);
    total++;
    if ({word_valid, word_data, word_cha, word_addr, frame_done, frame_count,
         reset_active, reset_cmd, err_abort} !== '0) begin
      bad++; $display("FAIL midword_reset: got data=%h fc=%0d ea=%b need all 0", word_data, frame_count, err_abort);
    end
    bt_res = 1'b0;
    clr_mon();
    idle(8);
    send_word(8'hAA, 4'd2);
    send_word(8'h55, 4'd3);
    idle(10);
    total++;
    if (wq.size() != 2) begin bad++; $display("FAIL post_reset_words: got %0d need 2", wq.size()); end
    else begin
      total++;
      if (wq[0].d !== 8'hAA || wq[0].c !== 4'd0 || wq[0].a !== 4'd2 || wq[1].d !== 8'h55 || wq[1].c !== 4'd1 || wq[1].a !== 4'd3) begin
        bad++; $display("FAIL post_reset_frame: got %h/%0d/%0d %h/%0d/%0d need AA/0/2 55/1/3",
                        wq[0].d, wq[0].c, wq[0].a, wq[1].d, wq[1].c, wq[1].a);
      end
    end
    total++;
    if (frame_count !== 16'd1 || n_err != 0) begin bad++; $display("FAIL post_reset_count: got fc=%0d err=%0d need 1/0", frame_count, n_err); end
  endtask

  initial begin
    test_reset();
    test_reset_cmd();
    test_frame();
    test_stream();
    test_abort();
    test_bad_reset();
    test_midword_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
